// File: rtl/eda_push_queue_if.sv
// Pop-side valid/ready channel of eda_push_queue: the queue is the master,
// the window fetch stage is the slave.
interface eda_push_queue_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  pop_valid;
  logic                  pop_ready;
  logic [ADDR_WIDTH-1:0] pop_addr;

  modport master (output pop_valid, output pop_addr, input pop_ready);
  modport slave  (input pop_valid, input pop_addr, output pop_ready);
endinterface

// File: rtl/eda_push_queue.sv
// Serializes the comparator's equal-neighbour mask into neighbour addresses and
// queues them in a circular FIFO. Optional high-water mark: EDA_PUSH_QUEUE_HWM_EN.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 9
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 8
`endif

module eda_push_queue #(
  parameter int unsigned M            = `CFG_M,
  parameter int unsigned N            = `CFG_N,
  parameter int unsigned WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int unsigned ADDR_WIDTH   = `CFG_ADDR_WIDTH,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_pixel,
  input  logic [WINDOW_WIDTH-2:0]   push_positions,
  input  logic [ADDR_WIDTH-1:0]     center_addr,
  input  logic                      flush,
  output logic                      busy,
  eda_push_queue_if.master          pop_if,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      protocol_err
`ifdef EDA_PUSH_QUEUE_HWM_EN
  ,
  output logic [$clog2(DEPTH):0]    hwm
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned MW = WINDOW_WIDTH - 1;

  localparam logic [ADDR_WIDTH-1:0] N_A      = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [MW-1:0]         MASK_ONE = MW'(1);
  localparam logic [PW:0]           FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]           CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);

  if (WINDOW_WIDTH != 9 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      64'(M) * 64'(N) > (64'(1) << ADDR_WIDTH)) begin : g_cfg_check
    $error("eda_push_queue: unsupported parameter set");
  end

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state, state_nx;
  logic [MW-1:0]         mask_q, mask_nx, mask_clr;
  logic [ADDR_WIDTH-1:0] center_q, nb_addr;
  logic [2:0]            lsb;
  logic                  capture, wr_en, pop, full;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count_nx;
  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  assign busy             = (state == EMIT);
  assign full             = (count == FULL_CNT);
  assign pop_if.pop_valid = (count != '0);
  assign pop_if.pop_addr  = pop_if.pop_valid ? mem[rd_ptr] : '0;
  assign pop              = pop_if.pop_valid && pop_if.pop_ready;
  // A pop on a full FIFO frees the slot the serializer writes this same edge.
  assign wr_en            = busy && (!full || pop);
  assign mask_clr         = mask_q & (mask_q - MASK_ONE);

  always_comb begin
    lsb = '0;
    for (int unsigned i = MW; i > 0; i--)
      if (mask_q[i-1]) lsb = 3'(i - 1);
  end

  always_comb begin
    case (lsb)
      3'd0:    nb_addr = center_q - N_A - ONE_A;
      3'd1:    nb_addr = center_q - N_A;
      3'd2:    nb_addr = center_q - N_A + ONE_A;
      3'd3:    nb_addr = center_q - ONE_A;
      3'd4:    nb_addr = center_q + ONE_A;
      3'd5:    nb_addr = center_q + N_A - ONE_A;
      3'd6:    nb_addr = center_q + N_A;
      default: nb_addr = center_q + N_A + ONE_A;
    endcase
  end

  always_comb begin
    state_nx = state;
    mask_nx  = mask_q;
    capture  = 1'b0;
    case (state)
      IDLE: if (new_pixel && (push_positions != '0)) begin
        capture  = 1'b1;
        mask_nx  = push_positions;
        state_nx = EMIT;
      end
      EMIT: if (wr_en) begin
        mask_nx = mask_clr;
        if (mask_clr == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      mask_nx  = '0;
      capture  = 1'b0;
    end
  end

  always_comb begin
    count_nx = count;
    if (flush)               count_nx = '0;
    else if (wr_en && !pop)  count_nx = count + CNT_ONE;
    else if (!wr_en && pop)  count_nx = count - CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mask_q       <= '0;
      center_q     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      state  <= state_nx;
      mask_q <= mask_nx;
      count  <= count_nx;
      if (capture) center_q <= center_addr;
      if (new_pixel && busy) protocol_err <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= nb_addr;
  end

`ifdef EDA_PUSH_QUEUE_HWM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                hwm <= '0;
    else if (flush)           hwm <= '0;
    else if (count_nx > hwm)  hwm <= count_nx;
  end
`endif

endmodule

// File: tb/tb_eda_push_queue.sv
// Bench for eda_push_queue: a DEPTH=16 and a DEPTH=4 instance share stimulus and
// are compared each cycle against an address-list reference model.
module tb_eda_push_queue;
  localparam int unsigned AW = 8;
  localparam int          NC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       np = 1'b0, fl = 1'b0;
  logic [7:0] mask = '0, ctr = '0;
  logic       rdy [2];
  logic       busy0, busy1, err0, err1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;
`ifdef EDA_PUSH_QUEUE_HWM_EN
  logic [4:0] hwm0;
  logic [2:0] hwm1;
`endif

  eda_push_queue_if #(.ADDR_WIDTH(AW)) if0 ();
  eda_push_queue_if #(.ADDR_WIDTH(AW)) if1 ();
  assign if0.pop_ready = rdy[0];
  assign if1.pop_ready = rdy[1];

  eda_push_queue #(.M(4), .N(NC), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW), .DEPTH(16)) dut0 (
    .clk(clk), .reset(reset), .new_pixel(np), .push_positions(mask), .center_addr(ctr),
    .flush(fl), .busy(busy0), .pop_if(if0), .count(cnt0), .protocol_err(err0)
`ifdef EDA_PUSH_QUEUE_HWM_EN
    , .hwm(hwm0)
`endif
  );

  eda_push_queue #(.M(4), .N(NC), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .new_pixel(np), .push_positions(mask), .center_addr(ctr),
    .flush(fl), .busy(busy1), .pop_if(if1), .count(cnt1), .protocol_err(err1)
`ifdef EDA_PUSH_QUEUE_HWM_EN
    , .hwm(hwm1)
`endif
  );

  always #5 clk = ~clk;

  logic       ob_busy [2], ob_pv [2], ob_err [2];
  logic [7:0] ob_addr [2];
  logic [4:0] ob_cnt [2], ob_hwm [2];
  assign ob_busy[0] = busy0;        assign ob_busy[1] = busy1;
  assign ob_pv[0]   = if0.pop_valid; assign ob_pv[1]  = if1.pop_valid;
  assign ob_addr[0] = if0.pop_addr;  assign ob_addr[1] = if1.pop_addr;
  assign ob_err[0]  = err0;         assign ob_err[1]  = err1;
  assign ob_cnt[0]  = cnt0;         assign ob_cnt[1]  = {2'b00, cnt1};
`ifdef EDA_PUSH_QUEUE_HWM_EN
  assign ob_hwm[0] = hwm0;          assign ob_hwm[1] = {2'b00, hwm1};
`else
  assign ob_hwm[0] = '0;            assign ob_hwm[1] = '0;
`endif

  // Reference model: each capture expands to its full list of addresses;
  // the FIFO is a plain array with head/tail/occupancy.
  int         dep [2] = '{16, 4};
  int         off [8] = '{-NC-1, -NC, -NC+1, -1, 1, NC-1, NC, NC+1};
  logic [7:0] mf [2][16];
  logic [7:0] pend [2][8];
  int         mh [2], mt [2], mc [2], mhw [2], pn [2], pi [2];
  bit         merr [2];
  int         checks = 0, errors = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 0; mt[i] = 0; mc[i] = 0; mhw[i] = 0; pn[i] = 0; pi[i] = 0; merr[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      bit busy_b, pop, wr;
      busy_b = pi[i] < pn[i];
      if (np && busy_b) merr[i] = 1;
      if (fl) begin
        mh[i] = 0; mt[i] = 0; mc[i] = 0; pn[i] = 0; pi[i] = 0; mhw[i] = 0;
      end else begin
        pop = (mc[i] > 0) && rdy[i];
        wr  = busy_b && ((mc[i] < dep[i]) || pop);
        if (pop) begin mh[i] = (mh[i] + 1) % dep[i]; mc[i]--; end
        if (wr) begin
          mf[i][mt[i]] = pend[i][pi[i]];
          pi[i]++;
          mt[i] = (mt[i] + 1) % dep[i];
          mc[i]++;
        end
        if (np && !busy_b && mask != 8'h00) begin
          pn[i] = 0; pi[i] = 0;
          for (int b = 0; b < 8; b++)
            if (mask[b]) begin pend[i][pn[i]] = 8'(int'(ctr) + off[b]); pn[i]++; end
        end
        if (mc[i] > mhw[i]) mhw[i] = mc[i];
      end
    end
  endfunction

  function automatic bit model_idle();
    return (pi[0] >= pn[0]) && (pi[1] >= pn[1]) && mc[0] == 0 && mc[1] == 0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 32'(ob_busy[i]), 32'(pi[i] < pn[i]));
      chk("pop_valid", i, 32'(ob_pv[i]), 32'(mc[i] > 0));
      chk("count", i, 32'(ob_cnt[i]), 32'(mc[i]));
      chk("protocol_err", i, 32'(ob_err[i]), 32'(merr[i]));
      if (mc[i] > 0) chk("pop_addr", i, 32'(ob_addr[i]), 32'(mf[i][mh[i]]));
`ifdef EDA_PUSH_QUEUE_HWM_EN
      chk("hwm", i, 32'(ob_hwm[i]), 32'(mhw[i]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain();
    int k = 0;
    np = 0; fl = 0; rdy[0] = 1; rdy[1] = 1;
    while (k < 64 && !model_idle()) begin step(); k++; end
    chk("drain_bound", 0, 32'(k < 64), 32'd1);
  endtask

  logic [7:0] got [2][$];
  logic [7:0] exp_order [8] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10};

  initial begin
    rdy[0] = 0; rdy[1] = 0;
    model_reset();
    #12;
    check_all();
    chk("reset_addr", 0, 32'(ob_addr[0]), 32'd0);
    chk("reset_addr", 1, 32'(ob_addr[1]), 32'd0);
    reset = 0;

    // mask 81 at centre 5: addresses 0 then 10
    ctr = 8'd5; mask = 8'h81; np = 1; step(); np = 0;
    step(); step();
    chk("t1_peak", 0, 32'(ob_cnt[0]), 32'd2);
    chk("t1_head", 0, 32'(ob_addr[0]), 32'd0);
    drain();

    // mask FF with no consumer: DEPTH=16 holds all 8, DEPTH=4 stalls
    rdy[0] = 0; rdy[1] = 0; mask = 8'hFF; np = 1; step(); np = 0;
    for (int c = 0; c < 8; c++) step();
    chk("t2_count16", 0, 32'(ob_cnt[0]), 32'd8);
    chk("t2_count4", 1, 32'(ob_cnt[1]), 32'd4);
    chk("t2_stall_busy", 1, 32'(ob_busy[1]), 32'd1);
    rdy[0] = 1; rdy[1] = 1;
    for (int k = 0; k < 40 && !model_idle(); k++) begin
      for (int i = 0; i < 2; i++) if (ob_pv[i]) got[i].push_back(ob_addr[i]);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("t2_npops", i, 32'(got[i].size()), 32'd8);
      for (int j = 0; j < 8 && j < got[i].size(); j++) chk("t2_order", i, 32'(got[i][j]), 32'(exp_order[j]));
    end

    // second new_pixel while busy is ignored and flagged
    rdy[0] = 0; rdy[1] = 0; mask = 8'h0F; np = 1; step();
    mask = 8'hF0; step(); np = 0;
    step(); step(); step();
    chk("t3_err", 0, 32'(ob_err[0]), 32'd1);
    chk("t3_count", 0, 32'(ob_cnt[0]), 32'd4);
    chk("t3_idle", 0, 32'(ob_busy[0]), 32'd0);
    drain();

    // back-to-back 3C requests with a continuous consumer wrap the pointers
    for (int r = 0; r < 5; r++) begin
      ctr = 8'(20 + 7 * r); mask = 8'h3C; np = 1; step(); np = 0;
      drain();
    end

    // flush in the middle of an FF emission
    rdy[0] = 0; rdy[1] = 0; ctr = 8'd5; mask = 8'hFF; np = 1; step(); np = 0;
    step(); step(); step();
    chk("t5_pre", 0, 32'(ob_cnt[0]), 32'd3);
    fl = 1; step(); fl = 0;
    chk("t5_count", 0, 32'(ob_cnt[0]), 32'd0);
    chk("t5_valid", 0, 32'(ob_pv[0]), 32'd0);
    chk("t5_busy", 0, 32'(ob_busy[0]), 32'd0);
`ifdef EDA_PUSH_QUEUE_HWM_EN
    chk("t5_hwm", 0, 32'(ob_hwm[0]), 32'd0);
`endif

    // asynchronous reset mid-emission
    mask = 8'hE7; ctr = 8'd40; np = 1; step(); np = 0; step(); step();
    #2 reset = 1;
    #1 model_reset();
    check_all();
    #2 reset = 0;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 39) == 0);
      np = !fl && ($urandom_range(0, 3) == 0);
      mask = 8'($urandom); ctr = 8'($urandom);
      rdy[0] = ($urandom_range(0, 2) != 0);
      rdy[1] = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
